// File: rtl/alu_pkg.sv
// Shared types for the ALU share arbiter: ALU control codes, arbiter FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD      = 4'b0000,
    ALU_SLL      = 4'b0001,
    ALU_SLT      = 4'b0010,
    ALU_SLTU     = 4'b0011,
    ALU_XOR      = 4'b0100,
    ALU_SRL      = 4'b0101,
    ALU_OR       = 4'b0110,
    ALU_AND      = 4'b0111,
    ALU_SUB      = 4'b1000,
    ALU_BEQ      = 4'b1001,
    ALU_BNE      = 4'b1010,
    ALU_BLT      = 4'b1011,
    ALU_BGE      = 4'b1100,
    ALU_SRA      = 4'b1101,
    ALU_RESERVED = 4'b1110,
    ALU_BGEU     = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // The reserved code never reaches the ALU; it is answered with an error.
  function automatic logic is_reserved(input logic [ALU_CTRL_W-1:0] ctrl);
    return ctrl == ALU_RESERVED;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of both requester channels, both response channels and the ALU port.
// Latency: n/a (wiring only).
// Backpressure: valid/ready per channel; slave = arbiter side, master = requesters + ALU.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32
);
  import alu_pkg::*;

  // requester 0 (main pipeline)
  logic                  i_req0_valid;
  logic                  o_req0_ready;
  logic [ALU_CTRL_W-1:0] i_req0_ctrl;
  logic [XLEN-1:0]       i_req0_a;
  logic [XLEN-1:0]       i_req0_b;
  logic                  o_resp0_valid;
  logic                  i_resp0_ready;
  logic [XLEN-1:0]       o_resp0_data;
  logic                  o_resp0_err;
  // requester 1 (branch/address unit)
  logic                  i_req1_valid;
  logic                  o_req1_ready;
  logic [ALU_CTRL_W-1:0] i_req1_ctrl;
  logic [XLEN-1:0]       i_req1_a;
  logic [XLEN-1:0]       i_req1_b;
  logic                  o_resp1_valid;
  logic                  i_resp1_ready;
  logic [XLEN-1:0]       o_resp1_data;
  logic                  o_resp1_err;
  // external combinational ALU
  logic [ALU_CTRL_W-1:0] o_alu_ctrl;
  logic [XLEN-1:0]       o_alu_a;
  logic [XLEN-1:0]       o_alu_b;
  logic                  o_alu_valid;
  logic [XLEN-1:0]       i_alu_result;

  modport slave (
    input  i_req0_valid, i_req0_ctrl, i_req0_a, i_req0_b, i_resp0_ready,
    output o_req0_ready, o_resp0_valid, o_resp0_data, o_resp0_err,
    input  i_req1_valid, i_req1_ctrl, i_req1_a, i_req1_b, i_resp1_ready,
    output o_req1_ready, o_resp1_valid, o_resp1_data, o_resp1_err,
    output o_alu_ctrl, o_alu_a, o_alu_b, o_alu_valid,
    input  i_alu_result
  );

  modport master (
    output i_req0_valid, i_req0_ctrl, i_req0_a, i_req0_b, i_resp0_ready,
    input  o_req0_ready, o_resp0_valid, o_resp0_data, o_resp0_err,
    output i_req1_valid, i_req1_ctrl, i_req1_a, i_req1_b, i_resp1_ready,
    input  o_req1_ready, o_resp1_valid, o_resp1_data, o_resp1_err,
    input  o_alu_ctrl, o_alu_a, o_alu_b, o_alu_valid,
    output i_alu_result
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: favoured requester first, else the other one.
// Latency: grant is combinational from req; pointer updates on the advance edge.
// Backpressure: none; caller qualifies grant and pulses advance on acceptance.
// Ports: i_clk/i_rst_n, req[1:0] valids, advance (grant accepted), gnt[1:0] one-hot.
module rr_arbiter2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;  // index of the favoured requester

  always_comb begin
    gnt = 2'b00;
    if (req[ptr])       gnt[ptr]  = 1'b1;
    else if (req[~ptr]) gnt[~ptr] = 1'b1;
  end

  // After a grant the peer of the winner becomes favoured.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     ptr <= RR_INIT;
    else if (advance) ptr <= gnt[0];
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters with RR fairness.
// Latency: accept at T -> response valid at T+2 (T+1 for the reserved code); 1 op per 3 cycles.
// Backpressure: response held until consumed; no new grant while a response is pending.
// Ports: i_clk, i_rst_n (async active-low), bus = requester/response/ALU channels (slave modport).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  alu_share_arbiter_if.slave bus
);

  arb_state_e            state, state_nxt;
  logic [1:0]            gnt;
  logic                  hs;
  logic                  resp_hs;
  logic [ALU_CTRL_W-1:0] sel_ctrl;
  logic [XLEN-1:0]       sel_a, sel_b;
  logic [ALU_CTRL_W-1:0] lat_ctrl;
  logic [XLEN-1:0]       lat_a, lat_b;
  logic                  owner;
  logic [XLEN-1:0]       resp_data;
  logic                  resp_err;

  rr_arbiter2 #(.RR_INIT(RR_INIT)) u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .req     ({bus.i_req1_valid, bus.i_req0_valid}),
    .advance (hs),
    .gnt     (gnt)
  );

  // The arbiter only ever accepts in IDLE; its grant is the request handshake.
  assign hs       = (state == IDLE) && (gnt != 2'b00);
  assign sel_ctrl = gnt[1] ? bus.i_req1_ctrl : bus.i_req0_ctrl;
  assign sel_a    = gnt[1] ? bus.i_req1_a    : bus.i_req0_a;
  assign sel_b    = gnt[1] ? bus.i_req1_b    : bus.i_req0_b;
  // Only the owner's resp_ready matters; the other one is ignored.
  assign resp_hs  = (state == RESP) && (owner ? bus.i_resp1_ready : bus.i_resp0_ready);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = is_reserved(sel_ctrl) ? RESP : EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/owner capture on accept; result capture in EXEC.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_ctrl  <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      owner     <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (hs) begin
      lat_ctrl <= sel_ctrl;
      lat_a    <= sel_a;
      lat_b    <= sel_b;
      owner    <= gnt[1];
      if (is_reserved(sel_ctrl)) begin
        resp_data <= '0;
        resp_err  <= 1'b1;
      end
    end else if (state == EXEC) begin
      resp_data <= bus.i_alu_result;
      resp_err  <= 1'b0;
    end
  end

  // Outputs. Ready is gated by reset so nothing is accepted while reset is held.
  // ALU inputs are zeroed outside EXEC so the ALU sees no toggling.
  always_comb begin
    bus.o_req0_ready  = i_rst_n && (state == IDLE) && gnt[0];
    bus.o_req1_ready  = i_rst_n && (state == IDLE) && gnt[1];
    bus.o_alu_valid   = 1'b0;
    bus.o_alu_ctrl    = '0;
    bus.o_alu_a       = '0;
    bus.o_alu_b       = '0;
    bus.o_resp0_valid = 1'b0;
    bus.o_resp0_data  = '0;
    bus.o_resp0_err   = 1'b0;
    bus.o_resp1_valid = 1'b0;
    bus.o_resp1_data  = '0;
    bus.o_resp1_err   = 1'b0;
    if (state == EXEC) begin
      bus.o_alu_valid = 1'b1;
      bus.o_alu_ctrl  = lat_ctrl;
      bus.o_alu_a     = lat_a;
      bus.o_alu_b     = lat_b;
    end
    if (state == RESP) begin
      if (owner) begin
        bus.o_resp1_valid = 1'b1;
        bus.o_resp1_data  = resp_data;
        bus.o_resp1_err   = resp_err;
      end else begin
        bus.o_resp0_valid = 1'b1;
        bus.o_resp0_data  = resp_data;
        bus.o_resp0_err   = resp_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: single op, contention, backpressure,
// reserved code, lone requester and reset in the middle of an op.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.XLEN(32)) bus ();

  alu_share_arbiter #(.XLEN(32), .RR_INIT(1'b0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Reference ALU: only the codes the bench uses need real behaviour.
  always_comb begin
    case (bus.o_alu_ctrl)
      4'b0000: bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;
      4'b1000: bus.i_alu_result = bus.o_alu_a - bus.o_alu_b;
      default: bus.i_alu_result = bus.o_alu_a ^ bus.o_alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_req0_valid = 1'b0; bus.i_req0_ctrl = 4'h0; bus.i_req0_a = '0; bus.i_req0_b = '0;
    bus.i_req1_valid = 1'b0; bus.i_req1_ctrl = 4'h0; bus.i_req1_a = '0; bus.i_req1_b = '0;
    bus.i_resp0_ready = 1'b0; bus.i_resp1_ready = 1'b0;

    // ---- reset state ----
    #12;
    check("rst_ready0", bus.o_req0_ready, 0);
    check("rst_resp0_valid", bus.o_resp0_valid, 0);
    check("rst_resp0_data", bus.o_resp0_data, 0);
    check("rst_alu_valid", bus.o_alu_valid, 0);
    check("rst_alu_a", bus.o_alu_a, 0);
    bus.i_req0_valid = 1'b1;
    #1;
    check("rst_ready0_held", bus.o_req0_ready, 0);
    bus.i_req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // ---- single op: 5 + 7 ----
    bus.i_req0_valid = 1'b1; bus.i_req0_ctrl = 4'b0000; bus.i_req0_a = 32'd5; bus.i_req0_b = 32'd7;
    #1;
    check("single_ready0", bus.o_req0_ready, 1);
    check("single_ready1", bus.o_req1_ready, 0);
    tick();
    bus.i_req0_valid = 1'b0; bus.i_req0_a = 32'd99;  // must not be resampled
    #1;
    check("single_alu_valid", bus.o_alu_valid, 1);
    check("single_alu_ctrl", bus.o_alu_ctrl, 4'b0000);
    check("single_alu_a", bus.o_alu_a, 5);
    check("single_alu_b", bus.o_alu_b, 7);
    check("single_resp0_early", bus.o_resp0_valid, 0);
    tick();
    check("single_resp0_valid", bus.o_resp0_valid, 1);
    check("single_resp0_data", bus.o_resp0_data, 12);
    check("single_resp0_err", bus.o_resp0_err, 0);
    check("single_resp1_valid", bus.o_resp1_valid, 0);
    check("single_alu_idle", bus.o_alu_valid, 0);
    check("single_alu_a_zero", bus.o_alu_a, 0);
    bus.i_resp0_ready = 1'b1;
    tick();
    bus.i_resp0_ready = 1'b0;
    check("single_resp0_done", bus.o_resp0_valid, 0);

    // ---- contention from a fresh reset: strict alternation 0,1,0,1,... ----
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    bus.i_req0_valid = 1'b1; bus.i_req1_valid = 1'b1;
    bus.i_req0_ctrl = 4'b0000; bus.i_req1_ctrl = 4'b0000;
    bus.i_resp0_ready = 1'b1; bus.i_resp1_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.i_req0_a = 32'd10 + 32'(k);  bus.i_req0_b = 32'd1;
      bus.i_req1_a = 32'd100 + 32'(k); bus.i_req1_b = 32'd2;
      #1;
      check($sformatf("cont%0d_ready0", k), bus.o_req0_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("cont%0d_ready1", k), bus.o_req1_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      tick();
      check($sformatf("cont%0d_ready_stall", k), {bus.o_req1_ready, bus.o_req0_ready}, 0);
      if (k % 2 == 0) begin
        check($sformatf("cont%0d_resp0_valid", k), bus.o_resp0_valid, 1);
        check($sformatf("cont%0d_resp1_valid", k), bus.o_resp1_valid, 0);
        check($sformatf("cont%0d_resp0_data", k), bus.o_resp0_data, 32'd11 + 32'(k));
      end else begin
        check($sformatf("cont%0d_resp1_valid", k), bus.o_resp1_valid, 1);
        check($sformatf("cont%0d_resp0_valid", k), bus.o_resp0_valid, 0);
        check($sformatf("cont%0d_resp1_data", k), bus.o_resp1_data, 32'd102 + 32'(k));
      end
      tick();
    end
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    bus.i_resp0_ready = 1'b0; bus.i_resp1_ready = 1'b0;

    // ---- backpressure on response 1 ----
    bus.i_req1_valid = 1'b1; bus.i_req1_ctrl = 4'b0000; bus.i_req1_a = 32'd20; bus.i_req1_b = 32'd22;
    #1;
    check("bp_ready1", bus.o_req1_ready, 1);
    tick();
    bus.i_req1_valid = 1'b0;
    bus.i_req0_valid = 1'b1; bus.i_req0_ctrl = 4'b0000; bus.i_req0_a = 32'd1; bus.i_req0_b = 32'd1;
    #1;
    check("bp_ready0_exec", bus.o_req0_ready, 0);
    tick();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp%0d_resp1_valid", c), bus.o_resp1_valid, 1);
      check($sformatf("bp%0d_resp1_data", c), bus.o_resp1_data, 42);
      check($sformatf("bp%0d_ready0", c), bus.o_req0_ready, 0);
      tick();
    end
    bus.i_resp1_ready = 1'b1;
    tick();
    bus.i_resp1_ready = 1'b0;
    check("bp_resp1_released", bus.o_resp1_valid, 0);
    check("bp_ready0_after", bus.o_req0_ready, 1);
    tick();
    bus.i_req0_valid = 1'b0;
    tick();
    check("bp_resp0_valid", bus.o_resp0_valid, 1);
    check("bp_resp0_data", bus.o_resp0_data, 2);
    bus.i_resp0_ready = 1'b1;
    tick();
    bus.i_resp0_ready = 1'b0;

    // ---- reserved code on requester 1 ----
    bus.i_req1_valid = 1'b1; bus.i_req1_ctrl = 4'b1110; bus.i_req1_a = 32'd5; bus.i_req1_b = 32'd5;
    #1;
    check("rsv_ready1", bus.o_req1_ready, 1);
    tick();
    bus.i_req1_valid = 1'b0;
    #1;
    check("rsv_alu_valid", bus.o_alu_valid, 0);
    check("rsv_resp1_valid", bus.o_resp1_valid, 1);
    check("rsv_resp1_err", bus.o_resp1_err, 1);
    check("rsv_resp1_data", bus.o_resp1_data, 0);
    bus.i_resp1_ready = 1'b1;
    tick();
    bus.i_resp1_ready = 1'b0;

    // ---- lone requester 1 while pointer favours requester 0: 3 - 5 ----
    bus.i_req1_valid = 1'b1; bus.i_req1_ctrl = 4'b1000; bus.i_req1_a = 32'd3; bus.i_req1_b = 32'd5;
    #1;
    check("lone_ready1", bus.o_req1_ready, 1);
    check("lone_ready0", bus.o_req0_ready, 0);
    tick();
    bus.i_req1_valid = 1'b0;
    #1;
    check("lone_alu_ctrl", bus.o_alu_ctrl, 4'b1000);
    tick();
    check("lone_resp1_data", bus.o_resp1_data, 32'hFFFF_FFFE);
    check("lone_resp1_err", bus.o_resp1_err, 0);
    bus.i_resp1_ready = 1'b1;
    tick();
    bus.i_resp1_ready = 1'b0;

    // ---- reset while in EXEC (pointer has moved to requester 1) ----
    bus.i_req0_valid = 1'b1; bus.i_req0_ctrl = 4'b0000; bus.i_req0_a = 32'd1; bus.i_req0_b = 32'd2;
    tick();
    bus.i_req0_valid = 1'b0;
    #1;
    check("mid_alu_valid_pre", bus.o_alu_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_alu_valid", bus.o_alu_valid, 0);
    check("mid_alu_a", bus.o_alu_a, 0);
    check("mid_resp0_valid", bus.o_resp0_valid, 0);
    tick();
    check("mid_resp0_hold", bus.o_resp0_valid, 0);
    #3;
    rst_n = 1'b1;
    tick();
    check("mid_no_stale0", bus.o_resp0_valid, 0);
    check("mid_no_stale1", bus.o_resp1_valid, 0);
    bus.i_req0_valid = 1'b1; bus.i_req1_valid = 1'b1;
    #1;
    check("mid_first_ready0", bus.o_req0_ready, 1);
    check("mid_first_ready1", bus.o_req1_ready, 0);
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
